// File: rtl/branch_predictor_pkg.sv
// Shared constants for the dynamic branch predictor.
// Default table/counter sizes, counter reset value, BRANCH opcode.
package branch_predictor_pkg;

  localparam int DEF_INDEX_BITS = 6;
  localparam int DEF_CTR_WIDTH  = 2;
  localparam int DEF_PC_WIDTH   = 32;
  localparam int DEF_STAT_WIDTH = 32;

  localparam logic [6:0] OPC_BRANCH = 7'h63;

  // Weakly not-taken: 2^(w-1)-1
  function automatic int ctr_rst_val(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down next-value logic for one predictor counter.
// Clamps at all-ones going up and at zero going down.
import branch_predictor_pkg::*;

module bp_sat_counter #(
  parameter int W = DEF_CTR_WIDTH
) (
  input  logic [W-1:0] cur,
  input  logic         up,
  output logic [W-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (up && (cur != '1)) begin
      nxt = cur + W'(1);
    end else if (!up && (cur != '0)) begin
      nxt = cur - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: counter table, FD->X carry, training, stats.
// Define BP_GSHARE_EN for gshare indexing (global history XOR PC bits).
import branch_predictor_pkg::*;

module branch_predictor #(
  parameter int PC_WIDTH   = DEF_PC_WIDTH,
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int CTR_WIDTH  = DEF_CTR_WIDTH,
  parameter int STAT_WIDTH = DEF_STAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  guess_valid,
  input  logic [PC_WIDTH-1:0]   guess_pc,
  output logic                  guess_taken,
  input  logic                  check_valid,
  input  logic                  check_taken,
  output logic                  mispredict,
  output logic [STAT_WIDTH-1:0] br_count,
  output logic [STAT_WIDTH-1:0] mispred_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_WIDTH-1:0] CTR_RST =
    CTR_WIDTH'(ctr_rst_val(CTR_WIDTH));

  logic [CTR_WIDTH-1:0]  ctr [ENTRIES];
  logic [CTR_WIDTH-1:0]  ctr_nxt;
  logic [INDEX_BITS-1:0] idx;
  logic [INDEX_BITS-1:0] idx_q;
  logic                  pred_q;
  logic                  train;

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr;
  logic [INDEX_BITS-1:0] ghr_q;
  logic                  unused;

  assign idx = guess_pc[INDEX_BITS+1:2] ^ ghr;
  assign unused = ^{guess_pc[PC_WIDTH-1:INDEX_BITS+2],
                    guess_pc[1:0], ghr_q};

  // History advances at resolution only, never speculatively
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr   <= '0;
      ghr_q <= '0;
    end else begin
      if (!stall) ghr_q <= ghr;
      if (train) ghr <= {ghr[INDEX_BITS-2:0], check_taken};
    end
  end
`else
  logic unused;

  assign idx = guess_pc[INDEX_BITS+1:2];
  assign unused = ^{guess_pc[PC_WIDTH-1:INDEX_BITS+2],
                    guess_pc[1:0]};
`endif

  assign guess_taken = guess_valid & ctr[idx][CTR_WIDTH-1];
  assign mispredict  = check_valid & (check_taken != pred_q);
  assign train       = check_valid & ~stall;

  bp_sat_counter #(.W(CTR_WIDTH)) u_sat (
    .cur (ctr[idx_q]),
    .up  (check_taken),
    .nxt (ctr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      pred_q <= 1'b0;
    end else if (!stall) begin
      idx_q  <= idx;
      pred_q <= guess_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_RST;
    end else if (train) begin
      ctr[idx_q] <= ctr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (train) begin
      br_count <= br_count + STAT_WIDTH'(1);
      if (mispredict) mispred_count <= mispred_count + STAT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (default params, CTR_WIDTH=2).
// Follows BP_GSHARE_EN when defined for the build.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        guess_valid = 1'b0;
  logic [31:0] guess_pc = '0;
  logic        guess_taken;
  logic        check_valid = 1'b0;
  logic        check_taken = 1'b0;
  logic        mispredict;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int checks = 0;
  int errors = 0;

  logic [1:0]  m_ctr [64];
  logic [5:0]  m_ghr;
  logic [5:0]  m_idx_q;
  logic        m_pred_q;
  logic [31:0] m_br;
  logic [31:0] m_mis;
  logic [1:0]  sb [$];
  logic        last_guess;
  logic        last_mis;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .guess_valid   (guess_valid),
    .guess_pc      (guess_pc),
    .guess_taken   (guess_taken),
    .check_valid   (check_valid),
    .check_taken   (check_taken),
    .mispredict    (mispredict),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 2'b01;
    m_ghr = '0;
    m_idx_q = '0;
    m_pred_q = 1'b0;
    m_br = '0;
    m_mis = '0;
  endtask

  task automatic step(input string tag, input logic gv,
                      input logic [31:0] pc, input logic cv,
                      input logic ct, input logic st);
    logic [5:0] i;
    logic       eg;
    logic       em;
    logic [1:0] e;
    @(negedge clk);
    guess_valid = gv;
    guess_pc    = pc;
    check_valid = cv;
    check_taken = ct;
    stall       = st;
`ifdef BP_GSHARE_EN
    i = pc[7:2] ^ m_ghr;
`else
    i = pc[7:2];
`endif
    eg = gv & m_ctr[i][1];
    em = cv & (ct != m_pred_q);
    sb.push_back({eg, em});
    #1;
    e = sb.pop_front();
    last_guess = guess_taken;
    last_mis   = mispredict;
    check({tag, "_guess"}, 32'(guess_taken), 32'(e[1]));
    check({tag, "_mis"}, 32'(mispredict), 32'(e[0]));
    check({tag, "_br"}, br_count, m_br);
    check({tag, "_mcnt"}, mispred_count, m_mis);
    @(posedge clk);
    if (!st) begin
      if (cv) begin
        if (ct && m_ctr[m_idx_q] != 2'b11) m_ctr[m_idx_q]++;
        if (!ct && m_ctr[m_idx_q] != 2'b00) m_ctr[m_idx_q]--;
        m_br++;
        if (em) m_mis++;
        m_ghr = {m_ghr[4:0], ct};
      end
      m_idx_q  = i;
      m_pred_q = eg;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    guess_valid = 1'b1;
    guess_pc = 32'h100;
    check_valid = 1'b1;
    check_taken = 1'b1;
    stall = 1'b0;
    #1;
    check("rst_guess", 32'(guess_taken), 32'd0);
    check("rst_mis", 32'(mispredict), 32'd1);
    check("rst_br", br_count, 32'd0);
    check("rst_mcnt", mispred_count, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    guess_valid = 1'b0;
    check_valid = 1'b0;
  endtask

  // Predict in FD, then resolve in X on the next cycle
  task automatic branch(input string tag, input logic [31:0] pc,
                        input logic ct);
    step({tag, "_fd"}, 1'b1, pc, 1'b0, 1'b0, 1'b0);
    step({tag, "_x"}, 1'b0, 32'h0, 1'b1, ct, 1'b0);
  endtask

  initial begin
    model_reset();
    do_reset();

    branch("t1", 32'h100, 1'b1);
    branch("t2", 32'h100, 1'b1);
    step("look1", 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    check("train_taken", 32'(last_guess), 32'd1);
    step("nt1", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step("look2", 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    check("weak_taken", 32'(last_guess), 32'd1);

    for (int k = 0; k < 5; k++) branch("sat_up", 32'h100, 1'b1);
    for (int k = 0; k < 3; k++) branch("sat_dn", 32'h100, 1'b0);
    step("look3", 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    check("strong_nt", 32'(last_guess), 32'd0);
    step("nt_floor", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    branch("floor_up", 32'h100, 1'b1);
    step("look4", 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    check("floor_held", 32'(last_guess), 32'd0);

    do_reset();
    step("mp_fd", 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    step("mp_x", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("mp_flag", 32'(last_mis), 32'd1);
    step("mp_after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("mp_br1", br_count, 32'd1);
    check("mp_mcnt1", mispred_count, 32'd1);

    step("st_fd", 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      step("st_hold", 1'b1, 32'h3f4, 1'b1, 1'b1, 1'b1);
    check("st_br_held", br_count, 32'd1);
    step("st_rel", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step("st_after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("st_one_train", br_count, 32'd2);

    for (int k = 0; k < 300; k++) begin
      step("rnd", 1'($urandom), 32'($urandom_range(0, 255)),
           1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      if (k == 150) do_reset();
    end

    if (sb.size() != 0) check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
